range_counter: RTL
==================

// Module: range_counter
// PURPOSE
//  Parametrised modulo range counter, successor to the fixed 1..12 hour counter.
//  - Counts over [MIN,MAX], either up or down, in wrap or saturate mode.
//  - Range-checked load; carry in/out so instances cascade, e.g. a 1..12 hour
//    counter driven by a 0..59 minute counter.
//  - Sits in timekeeping/sequencing datapaths as the per-digit counting element.
// PARAMETERS
//  WIDTH     4   counter width in bits
//  MIN       1   lowest count value; reset value
//  MAX       12  highest count value
//  SATURATE  0   0: wrap at bounds; 1: hold at bounds
// PORTS
//  clk       in   1      single clock, rising edge
//  reset_n   in   1      asynchronous, active-low reset
//  enable    in   1      master enable; when low, all sync actions are ignored
//  clear     in   1      sync clear to MIN
//  load      in   1      sync load of d
//  d         in   WIDTH  load value
//  up_dn     in   1      1: count up; 0: count down
//  carry_in  in   1      count request; tie to 1 for a free-running counter
//  q         out  WIDTH  current count
//  carry_out out  1      combinational terminal count, for cascading
//  wrapped   out  1      registered 1-cycle pulse: a wrap or saturation hit occurred
//  load_err  out  1      registered 1-cycle pulse: an out-of-range load was rejected
// BEHAVIOUR
//  - Elaboration check: MIN < MAX <= 2**WIDTH-1, else $error.
//  - reset_n low, asynchronously: q=MIN, wrapped=0, load_err=0. Release is synchronous to clk.
//  - Each clk edge, in priority order (enable gates everything, as in the 1..12 counter):
//    1. enable=0: q holds; wrapped<=0; load_err<=0.
//    2. clear=1: q<=MIN. clear beats load and count.
//    3. load=1:
//       - d in [MIN,MAX]: q<=d.
//       - otherwise: q<=MIN and load_err<=1 for one cycle.
//       - load beats count.
//    4. carry_in=1, counting up:
//       - q<MAX: q<=q+1.
//       - q==MAX: q<=MIN if SATURATE=0; q holds if SATURATE=1. Either way wrapped<=1.
//    5. carry_in=1, counting down:
//       - q>MIN: q<=q-1.
//       - q==MIN: q<=MAX if SATURATE=0; q holds if SATURATE=1. Either way wrapped<=1.
//    6. carry_in=0: q holds.
//  - Out-of-range q can only arise via X or glitch. If it does, the next count step forces q<=MIN.
//  - wrapped and load_err are 0 in every cycle they are not set.
//  - carry_out = enable & carry_in & ~clear & ~load & (up_dn ? q==MAX : q==MIN).
//    It is combinational with zero latency. Cascading connects carry_out to the next stage's carry_in.
//  - Latency: q updates one clock after the control inputs are sampled.
//  - Arithmetic is WIDTH bits. Compare before incrementing or decrementing, so q never wraps mod 2**WIDTH.
//  - up_dn can change on any cycle. It takes effect the same edge.
// STRUCTURE
//  - Shared package counter_pkg:
//    - localparam enum for mode (CNT_WRAP=0, CNT_SAT=1).
//    - function in_range(v,lo,hi).
//  - Sub-module range_step (combinational): takes q, up_dn, MIN/MAX, SATURATE.
//    Returns q_next, at_bound. The top level holds the registers, the priority mux and the pulse flops.
// TESTING (defaults WIDTH=4, MIN=1, MAX=12, SATURATE=0 unless stated)
//  1. Reset and wrap:
//     - Drive reset_n=0 mid-count with q=7 -> q=1 immediately, with no clock.
//     - Release, then up 12 cycles -> q runs 2..12 then 1. wrapped=1 only the cycle after 12->1.
//  2. Down-count and priority:
//     - Down at q=1 -> q=12, carry_out=1 during q=1.
//     - clear=1, load=1, d=5 together -> q=1.
//     - enable=0 with clear=1 -> q holds.
//  3. Load checking:
//     - d=9 -> q=9, load_err=0.
//     - d=0 and d=13 -> q=1, load_err pulses once per rejected load.
//  4. SATURATE=1: up from 11 for 4 cycles -> q=12,12,12,12. wrapped=1 on each cycle q is held at 12.
//  5. Cascade:
//     - Two instances: lo=0..59, hi=1..12, lo.carry_out->hi.carry_in.
//     - Start at lo=59, hi=12, count up -> lo=0, hi=1 on the same edge.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the range counter family: counting mode and range test.
package counter_pkg;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  function automatic logic in_range(input int unsigned v,
                                    input int unsigned lo,
                                    input int unsigned hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/range_counter_step.sv
// Combinational next-count step over [MIN,MAX]: wraps or saturates at the bounds.
module range_step
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MIN      = 1,
  parameter int MAX      = 12,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up_dn,
  output logic [WIDTH-1:0] q_next,
  output logic             at_bound
);

  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam cnt_mode_e        MODE  = (SATURATE != 0) ? CNT_SAT : CNT_WRAP;

  logic q_ok;

  assign q_ok     = in_range(32'(q), MIN, MAX);
  assign at_bound = up_dn ? (q == MAX_V) : (q == MIN_V);

  // Bounds are compared before stepping, so the WIDTH-bit add never overflows;
  // an out-of-range value (only reachable via X or upset) recovers to MIN.
  always_comb begin
    q_next = MIN_V;
    if (q_ok) begin
      if (up_dn) begin
        if (q == MAX_V) begin
          q_next = (MODE == CNT_SAT) ? MAX_V : MIN_V;
        end else begin
          q_next = q + WIDTH'(1);
        end
      end else begin
        if (q == MIN_V) begin
          q_next = (MODE == CNT_SAT) ? MIN_V : MAX_V;
        end else begin
          q_next = q - WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: rtl/range_counter.sv
// Parametrised modulo range counter with range-checked load and cascadable carry.
module range_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MIN      = 1,
  parameter int MAX      = 12,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             up_dn,
  input  logic             carry_in,
  output logic [WIDTH-1:0] q,
  output logic             carry_out,
  output logic             wrapped,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN);

  if (!((MIN >= 0) && (MIN < MAX) && (MAX <= (1 << WIDTH) - 1))) begin : g_param_check
    $error("range_counter: need 0 <= MIN < MAX <= 2**WIDTH-1");
  end

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] step_q;
  logic             at_bound;
  logic             load_ok;
  logic             wrapped_reg;
  logic             wrapped_next;
  logic             load_err_reg;
  logic             load_err_next;

  range_step #(
    .WIDTH   (WIDTH),
    .MIN     (MIN),
    .MAX     (MAX),
    .SATURATE(SATURATE)
  ) u_step (
    .q       (q_reg),
    .up_dn   (up_dn),
    .q_next  (step_q),
    .at_bound(at_bound)
  );

  assign load_ok = in_range(32'(d), MIN, MAX);

  // Priority: enable gates everything, then clear, load, count.
  always_comb begin
    q_next        = q_reg;
    wrapped_next  = 1'b0;
    load_err_next = 1'b0;
    if (enable) begin
      if (clear) begin
        q_next = MIN_V;
      end else if (load) begin
        if (load_ok) begin
          q_next = d;
        end else begin
          q_next        = MIN_V;
          load_err_next = 1'b1;
        end
      end else if (carry_in) begin
        q_next       = step_q;
        wrapped_next = at_bound;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_reg        <= MIN_V;
      wrapped_reg  <= 1'b0;
      load_err_reg <= 1'b0;
    end else begin
      q_reg        <= q_next;
      wrapped_reg  <= wrapped_next;
      load_err_reg <= load_err_next;
    end
  end

  assign q         = q_reg;
  assign wrapped   = wrapped_reg;
  assign load_err  = load_err_reg;
  // Zero-latency terminal count so a following stage steps on the same edge.
  assign carry_out = enable & carry_in & ~clear & ~load & at_bound;

endmodule
